// File: rtl/ps2_key_pkg.sv
// Shared constants and channel state encoding for the PS/2 key repeater.
// Latency: n/a (declarations only).
// Backpressure: n/a; the PS/2 byte stream cannot be stalled.
// Contents: PS/2 prefix byte values, key-code width, channel FSM state type.
package ps2_key_pkg;

  // PS/2 set-2 prefix bytes: extended-key prefix and break (key-up) prefix.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Key code = {extended flag, scan byte}.
  localparam int KEY_CODE_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS  = 3'd1,
    ST_DELAY  = 3'd2,
    ST_REPEAT = 3'd3,
    ST_HOLD   = 3'd4
  } chan_state_e;

endpackage

// File: rtl/ps2_key_repeater_channel.sv
// Per-key typematic channel: press pulse, delayed repeat pulses, release pulse, held level.
// Latency: outputs registered, one cycle after the make/break strobe.
// Backpressure: none; strobes are single-cycle and always consumed.
// Ports: clk_i/rst_i (sync active-high), make_i/brk_i matched strobes, repeat_en_i,
//        pulse_o, release_o, held_o.
module ps2_key_channel
  import ps2_key_pkg::*;
#(
  parameter int DELAY_CYCLES  = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic make_i,
  input  logic brk_i,
  input  logic repeat_en_i,
  output logic pulse_o,
  output logic release_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  chan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             rel_q;
  logic             held_q;

  // The counter reads 0 in the cycle a pulse is visible, so an expiry decided
  // at count N-1 puts the next pulse exactly N cycles after the previous one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
      if (state_q != ST_IDLE && brk_i) begin
        // Break has priority over a coincident counter expiry.
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        held_q  <= 1'b0;
        rel_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (make_i) begin
              state_q <= ST_PRESS;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
              held_q  <= 1'b1;
            end
          end
          ST_PRESS: begin
            // repeat_en is sampled here only.
            if (repeat_en_i) begin
              state_q <= ST_DELAY;
              cnt_q   <= CNT_W'(1);
            end else begin
              state_q <= ST_HOLD;
              cnt_q   <= '0;
            end
          end
          ST_DELAY: begin
            if (cnt_q == DLY_LAST) begin
              state_q <= ST_REPEAT;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (cnt_q == RPT_LAST) begin
              cnt_q   <= '0;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_HOLD: begin
            cnt_q <= '0;
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse_o   = pulse_q;
  assign release_o = rel_q;
  assign held_o    = held_q;

endmodule

// File: rtl/ps2_key_repeater.sv
// Multi-key PS/2 matcher with typematic repeat: prefix decoder plus NUM_KEYS channels.
// Latency: matching make/break byte strobed in cycle T gives pulse/release_pulse in T+1.
// Backpressure: none; every ps2_pulse byte is consumed in its strobe cycle.
// Ports: clk, rst (sync active-high), ps2_out/ps2_pulse byte input, key_codes (9 bits/slot),
//        repeat_en, pulse, release_pulse, held, leds {ext_flag, brk_flag, 2'b0, held[3:0]}.
module ps2_key_repeater
  import ps2_key_pkg::*;
#(
  parameter int NUM_KEYS      = 8,
  parameter int DELAY_CYCLES  = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 26
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     ps2_out,
  input  logic                           ps2_pulse,
  input  logic [KEY_CODE_W*NUM_KEYS-1:0] key_codes,
  input  logic [NUM_KEYS-1:0]            repeat_en,
  output logic [NUM_KEYS-1:0]            pulse,
  output logic [NUM_KEYS-1:0]            release_pulse,
  output logic [NUM_KEYS-1:0]            held,
  output logic [7:0]                     leds
);

  logic                  ext_q, ext_d;
  logic                  brk_q, brk_d;
  logic                  code_vld;
  logic                  code_brk;
  logic [KEY_CODE_W-1:0] code;

  // Prefix decoder: E0/F0 only set flags; any other byte completes a code
  // and clears both flags in the same cycle.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    code_vld = 1'b0;
    code_brk = brk_q;
    code     = {ext_q, ps2_out};
    if (ps2_pulse) begin
      if (ps2_out == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (ps2_out == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        code_vld = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic [KEY_CODE_W-1:0] slot_code;
    logic                  hit;
    assign slot_code = key_codes[KEY_CODE_W*i +: KEY_CODE_W];
    assign hit       = code_vld && (code == slot_code);

    ps2_key_channel #(
      .DELAY_CYCLES  (DELAY_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .make_i      (hit && !code_brk),
      .brk_i       (hit && code_brk),
      .repeat_en_i (repeat_en[i]),
      .pulse_o     (pulse[i]),
      .release_o   (release_pulse[i]),
      .held_o      (held[i])
    );
  end

  // Debug nibble shows held for channels 0..3; absent channels read 0.
  logic [3:0] held_lo;
  for (genvar j = 0; j < 4; j++) begin : g_led
    if (j < NUM_KEYS) begin : g_on
      assign held_lo[j] = held[j];
    end else begin : g_off
      assign held_lo[j] = 1'b0;
    end
  end

  assign leds = {ext_q, brk_q, 2'b00, held_lo};

endmodule

// File: tb/tb_ps2_key_repeater.sv
module tb_ps2_key_repeater;
  localparam int NK = 4;
  localparam int DC = 20;
  localparam int RC = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    ps2_out = 8'h00;
  logic          ps2_pulse = 1'b0;
  logic [9*NK-1:0] key_codes;
  logic [NK-1:0] repeat_en;
  logic [NK-1:0] pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] held;
  logic [7:0]    leds;

  ps2_key_repeater #(
    .NUM_KEYS      (NK),
    .DELAY_CYCLES  (DC),
    .REPEAT_CYCLES (RC),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_out       (ps2_out),
    .ps2_pulse     (ps2_pulse),
    .key_codes     (key_codes),
    .repeat_en     (repeat_en),
    .pulse         (pulse),
    .release_pulse (release_pulse),
    .held          (held),
    .leds          (leds)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected events, encoded as cycle*16 + kind*4 + channel (kind 0=pulse, 1=release).
  int exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ev(input int c, input int k, input int ch);
    return c * 16 + k * 4 + ch;
  endfunction

  // Every asserted strobe must match the next expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        for (int ch = 0; ch < NK; ch++) begin
          logic b;
          b = (k == 0) ? pulse[ch] : release_pulse[ch];
          if (b === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious", ev(cyc, k, ch), 32'hFFFF_FFFF);
            else                   chk("evt", ev(cyc, k, ch), exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe byte in the current cycle; returns one cycle later.
  task automatic send(input logic [7:0] b);
    ps2_out   = b;
    ps2_pulse = 1'b1;
    tick();
    ps2_pulse = 1'b0;
    ps2_out   = 8'h00;
  endtask

  task automatic idle_to(input int t);
    if (cyc > t) chk("sched", cyc, t);
    while (cyc < t) tick();
  endtask

  int t0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    key_codes = {9'h1FF, 9'h029, 9'h175, 9'h01C};
    repeat_en = 4'b0011;
    repeat (3) tick();
    chk("rst_pulse", pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_held", held, 0);
    chk("rst_leds", leds, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Key0 press, typematic repeats, release after 50 cycles.
    t0 = cyc + 2;
    exp_q.push_back(ev(t0 + 1, 0, 0));
    for (int k = 0; k <= 6; k++) exp_q.push_back(ev(t0 + 1 + DC + RC * k, 0, 0));
    exp_q.push_back(ev(t0 + 52, 1, 0));
    idle_to(t0);
    send(8'h1C);
    idle_to(t0 + 30);
    chk("s1_held", held, 4'b0001);
    chk("s1_leds", leds, 8'h01);
    idle_to(t0 + 50);
    send(8'hF0);
    chk("s1_brkflag", leds, 8'h41);
    send(8'h1C);
    idle_to(t0 + 54);
    chk("s1_held_off", held, 0);

    // Extended key1: E0 75 press, E0 F0 75 release; bare 75 and idle break ignored.
    t0 = cyc + 2;
    exp_q.push_back(ev(t0 + 2, 0, 1));
    exp_q.push_back(ev(t0 + 5, 1, 1));
    idle_to(t0);
    send(8'hE0);
    chk("s2_extflag", leds, 8'h80);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    idle_to(t0 + 10);
    send(8'h75);
    idle_to(t0 + 12);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    idle_to(t0 + 20);
    chk("s2_held", held, 0);
    chk("s2_flags", leds, 0);

    // Key2 without repeat; enabling repeat mid-hold has no effect.
    t0 = cyc + 2;
    exp_q.push_back(ev(t0 + 1, 0, 2));
    exp_q.push_back(ev(t0 + 103, 1, 2));
    idle_to(t0);
    send(8'h29);
    idle_to(t0 + 10);
    repeat_en[2] = 1'b1;
    idle_to(t0 + 50);
    chk("s3_held", held, 4'b0100);
    idle_to(t0 + 101);
    send(8'hF0);
    send(8'h29);
    idle_to(t0 + 105);
    chk("s3_held_off", held, 0);
    repeat_en[2] = 1'b0;

    // Keyboard auto-repeat makes while held: timing unchanged.
    t0 = cyc + 2;
    exp_q.push_back(ev(t0 + 1, 0, 0));
    for (int k = 0; k <= 10; k++) exp_q.push_back(ev(t0 + 1 + DC + RC * k, 0, 0));
    exp_q.push_back(ev(t0 + 72, 1, 0));
    idle_to(t0);
    send(8'h1C);
    for (int k = 1; k <= 6; k++) begin
      idle_to(t0 + 10 * k);
      send(8'h1C);
    end
    idle_to(t0 + 70);
    send(8'hF0);
    send(8'h1C);
    idle_to(t0 + 75);

    // Break lands in the cycle the delay counter expires: release only.
    t0 = cyc + 2;
    exp_q.push_back(ev(t0 + 1, 0, 0));
    exp_q.push_back(ev(t0 + 21, 1, 0));
    idle_to(t0);
    send(8'h1C);
    idle_to(t0 + 19);
    send(8'hF0);
    send(8'h1C);
    idle_to(t0 + 25);

    // Reset while key0 held: outputs clear with no release; new press works.
    t0 = cyc + 2;
    exp_q.push_back(ev(t0 + 1, 0, 0));
    exp_q.push_back(ev(t0 + 11, 0, 0));
    exp_q.push_back(ev(t0 + 16, 1, 0));
    idle_to(t0);
    send(8'h1C);
    idle_to(t0 + 5);
    chk("s6_pre_held", held, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_pulse", pulse, 0);
    chk("s6_release", release_pulse, 0);
    chk("s6_held", held, 0);
    chk("s6_leds", leds, 0);
    idle_to(t0 + 10);
    send(8'h1C);
    idle_to(t0 + 14);
    send(8'hF0);
    send(8'h1C);
    idle_to(t0 + 20);

    // Duplicate code in slot 3: both channels respond together.
    key_codes[35:27] = 9'h01C;
    t0 = cyc + 2;
    exp_q.push_back(ev(t0 + 1, 0, 0));
    exp_q.push_back(ev(t0 + 1, 0, 3));
    exp_q.push_back(ev(t0 + 5, 1, 0));
    exp_q.push_back(ev(t0 + 5, 1, 3));
    idle_to(t0);
    send(8'h1C);
    idle_to(t0 + 2);
    chk("s7_held", held, 4'b1001);
    idle_to(t0 + 3);
    send(8'hF0);
    send(8'h1C);
    idle_to(t0 + 10);
    chk("s7_held_off", held, 0);

    idle_to(cyc + 30);
    chk("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_repeater.md
Name: ps2_key_repeater

Overview:
- Multi-key successor to the single-key PS/2 button matcher; sits downstream of the PS/2 byte receiver (ps2_out/ps2_pulse).
- Matches up to NUM_KEYS programmable scan codes, including E0-extended codes.
- Per key: one-cycle press pulse, then typematic repeat pulses after a programmable delay, a release pulse, and a held level.
- Feeds game/UI logic that currently uses per-key button pulses.

Parameters:
NUM_KEYS, 8, number of independent key channels
DELAY_CYCLES, 25000000, clock cycles from press pulse to first repeat pulse (>=2)
REPEAT_CYCLES, 5000000, clock cycles between successive repeat pulses (>=2)
CNT_W, 26, counter width; must hold max(DELAY_CYCLES, REPEAT_CYCLES)

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  synchronous, active-high reset
ps2_out  in  8  received PS/2 byte, valid when ps2_pulse=1
ps2_pulse  in  1  one-cycle strobe, new byte on ps2_out
key_codes  in  9*NUM_KEYS  per-key code: bit8=extended (E0-prefixed), bits7:0=scan byte; slot i at [9i+8:9i]
repeat_en  in  NUM_KEYS  per-key typematic enable
pulse  out  NUM_KEYS  press/repeat strobe, one cycle each
release_pulse  out  NUM_KEYS  one-cycle strobe on key release
held  out  NUM_KEYS  high from press pulse until release
leds  out  8  debug: {ext_flag, brk_flag, 2'b0, OR of held[3:0] per channel 0..3}

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on rst. Every output is 0 in the cycle after rst=1.
- Reset: clears both prefix flags, all channel FSMs to IDLE, and all counters. Reset mid-operation drops held without a release_pulse.
- Prefix decoder: acts only on ps2_pulse=1.
  - Byte 8'hE0 sets ext_flag.
  - Byte 8'hF0 sets brk_flag.
  - Any other byte forms code {ext_flag, byte}, is a make if brk_flag=0 and a break if brk_flag=1, and clears both flags in the same cycle.
  - Prefix bytes E0/F0 never match a key.
- Channel FSM, one per key. States IDLE, PRESS, DELAY, REPEAT, HOLD.
  - IDLE: on make matching key_codes[i], go to PRESS.
  - PRESS, exactly one cycle: pulse[i]=1, held[i]=1, counter cleared. Next state is DELAY if repeat_en[i]=1, otherwise HOLD.
  - DELAY: counter increments each cycle. When counter=DELAY_CYCLES-1, emit pulse, clear counter, go to REPEAT.
  - REPEAT: counter increments. When counter=REPEAT_CYCLES-1, emit pulse and clear counter.
  - HOLD: no pulses; waits for break.
  - Any non-IDLE state: on matching break, go to IDLE with release_pulse[i]=1 for one cycle and held[i] deasserted the same cycle.
- Latency:
  - A matching make byte strobed in cycle T gives pulse in cycle T+1.
  - First repeat pulse is DELAY_CYCLES cycles after the press pulse.
  - Later repeat pulses are every REPEAT_CYCLES cycles.
  - Release_pulse appears in cycle T+1 for a break strobed in cycle T.
- Boundary conditions:
  - Keyboard auto-repeat makes for a key already held are ignored; they cause no pulse and no counter reset.
  - Break and counter expiry in the same cycle: break wins, no pulse.
  - Break for a key in IDLE: ignored, no release_pulse.
  - repeat_en[i] is sampled only when leaving PRESS; changing it later has no effect until the next press.
  - Duplicate codes in two slots: both channels respond identically.
  - Counter never wraps; it is cleared on every expiry.
  - key_codes may change at any time and take effect on the next ps2_pulse.
- All outputs are registered.

Decomposition:
- Package ps2_key_pkg holds:
  - localparams PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the channel state encoding (IDLE, PRESS, DELAY, REPEAT, HOLD, 3 bits);
  - the key-code width constant (9).
- Sub-module ps2_key_channel holds the per-key FSM, counter and outputs, instantiated NUM_KEYS times in a generate loop.
- The top level holds only the prefix decoder and the make/break strobe fan-out.

Test Plan (NUM_KEYS=4, DELAY_CYCLES=20, REPEAT_CYCLES=5, key0=9'h01C, key1=9'h175, repeat_en=4'b0011):
- Bytes 1C, then F0,1C after 50 cycles -> pulse[0] at +1, +21, +26, +31...; release_pulse[0] one cycle after the second 1C; held[0] high in between.
- Bytes E0,75, then E0,F0,75 -> key1 press pulse; bare 75 (no E0) produces no pulse on key1.
- Key2=9'h029 with repeat_en[2]=0; bytes 29, wait 100 cycles, F0,29 -> exactly one pulse[2], held[2] high for the whole hold, one release_pulse[2].
- Bytes 1C, then 1C again every 10 cycles for 60 cycles -> repeat timing unchanged from the first scenario, no extra pulses.
- Break byte 1C strobed in the exact cycle the key0 counter reaches 19 -> no pulse that cycle, release_pulse[0]=1.
- Key0 held, rst=1 for one cycle -> the next cycle all outputs are 0, no release_pulse; a new 1C press pulses normally.
